// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage: condition codes,
// NZCV flag bit positions and register index width.
package alu_pkg;

    localparam int REG_ADDR_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        EQ = 4'd0,
        NE = 4'd1,
        CS = 4'd2,
        CC = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        VS = 4'd6,
        VC = 4'd7,
        HI = 4'd8,
        LS = 4'd9,
        GE = 4'd10,
        LT = 4'd11,
        GT = 4'd12,
        LE = 4'd13,
        AL = 4'd14,
        NV = 4'd15
    } cond_e;

endpackage

// File: rtl/alu_result_stage_cond_eval.sv
// Combinational condition-code evaluation against the committed NZCV flags.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            EQ:      pass = z;
            NE:      pass = !z;
            CS:      pass = c;
            CC:      pass = !c;
            MI:      pass = n;
            PL:      pass = !n;
            VS:      pass = v;
            VC:      pass = !v;
            HI:      pass = c && !z;
            LS:      pass = !c || z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = !z && (n == v);
            LE:      pass = z || (n != v);
            AL:      pass = 1'b1;
            NV:      pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: NZCV flag register, condition squash and a small result FIFO
// toward writeback. Optional squash counter enabled by ALU_RESULT_SQUASH_CNT_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     result_i,
    input  logic [3:0]            status_i,
    input  logic                  set_status_i,
    input  logic [3:0]            cond_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  wb_en_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_data_o,
    output logic [REG_ADDR_W-1:0] out_rd_o,
    output logic                  out_wb_en_o,
    output logic [3:0]            flags_o,
    output logic [15:0]           squash_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0]     data_mem [DEPTH];
    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic                  wb_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       flags_q;

    logic pass, accept, push, pop;

    cond_eval u_cond_eval (
        .cond  (cond_i),
        .flags (flags_q),
        .pass  (pass)
    );

    assign in_ready_o  = (count != FULL_CNT);
    assign out_valid_o = (count != '0);
    assign accept      = in_valid_i && in_ready_o;
    assign push        = accept && pass;
    assign pop         = out_valid_o && out_ready_i;

    // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            flags_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                rd_mem[i]   <= '0;
                wb_mem[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= result_i;
                rd_mem[wr_ptr]   <= rd_i;
                wb_mem[wr_ptr]   <= wb_en_i;
                wr_ptr           <= wr_ptr + PTR_W'(1);
                if (set_status_i) begin
                    flags_q <= status_i;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty FIFO presents zeros rather than stale entries.
    assign out_data_o  = out_valid_o ? data_mem[rd_ptr] : '0;
    assign out_rd_o    = out_valid_o ? rd_mem[rd_ptr]   : '0;
    assign out_wb_en_o = out_valid_o ? wb_mem[rd_ptr]   : 1'b0;
    assign flags_o     = flags_q;

`ifdef ALU_RESULT_SQUASH_CNT_EN
    logic [15:0] squash_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            squash_q <= '0;
        end else if (accept && !pass && (squash_q != 16'hFFFF)) begin
            squash_q <= squash_q + 16'd1;
        end
    end

    assign squash_cnt_o = squash_q;
`else
    assign squash_cnt_o = '0;
`endif

endmodule
